dmem_pipe: RTL
==============

DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, byte-address width; capacity 2**ADDR_W bytes, organised as 2**(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter RD_LAT, default 1, load latency in cycles; legal values 1 and 2.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-015 rsp_err  output  1  request was misaligned, out of range, or had an illegal size.

Function
REQ-016 A request SHALL be accepted in a cycle where req_valid && req_ready.
REQ-017 FSM states SHALL be IDLE, RD and RSP; req_ready SHALL be 1 only in IDLE.
REQ-018 IDLE transitions:
- accepted load with RD_LAT=2 goes to RD;
- any other accepted request goes to RSP;
- with no request, stay in IDLE.
REQ-019 RD SHALL last exactly one cycle, then go to RSP.
REQ-020 RSP SHALL hold rsp_valid and keep rsp_rdata/rsp_err stable until rsp_ready=1, then go to IDLE.
REQ-021 Latency: a store accepted in cycle T SHALL update memory at the posedge ending T, with rsp_valid asserted in T+1.
REQ-022 Latency: a load accepted in cycle T SHALL assert rsp_valid in T+RD_LAT.
REQ-023 The request SHALL be flagged as an error when any of these holds:
- req_size=3;
- half with addr[0]=1;
- word with addr[1:0]!=0;
- addr[31:ADDR_W]!=0.
REQ-024 An errored request SHALL NOT modify memory, and SHALL respond with rsp_err=1 and rsp_rdata=0 at normal latency.
REQ-025 Store lanes:
- byte writes wdata[7:0] to lane addr[1:0];
- half writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1};
- word writes all four lanes;
- unselected lanes SHALL be unchanged.
REQ-026 Load data: the addressed byte/half/word SHALL be extracted and right-justified, then sign- or zero-extended per req_signed; for words, req_signed is ignored.
REQ-027 Lane mapping SHALL be little-endian: byte k of a word sits at bits [8k+7:8k].
REQ-028 Store responses SHALL have rsp_rdata=0 and rsp_err=0.
REQ-029 req_valid in a non-IDLE state SHALL be ignored; the requester holds the request until req_ready.
REQ-030 When rsp_ready=1 in the same cycle rsp_valid first rises, the response SHALL be consumed and the FSM SHALL return to IDLE next cycle.

Reset
REQ-031 On rst_n low (asynchronous), outputs SHALL be: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 Reset mid-operation SHALL discard any pending load or response.
REQ-034 A store already committed at an earlier posedge SHALL remain in memory after reset.

Structure
REQ-035 Shared package dmem_pkg SHALL hold the size encodings SZ_B/SZ_H/SZ_W/SZ_BAD and the FSM state encodings.
REQ-036 Sub-module dmem_bank SHALL implement the word RAM: 4 byte-write enables, one synchronous read port, no reset.
REQ-037 dmem_pipe SHALL contain the FSM, error check, lane steering and load extension.

Verification
REQ-038 Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid in T+RD_LAT.
REQ-039 Store byte 0x5A at 0x13 over 0xDEADBEEF -> load word gives 0x5AADBEEF; load signed byte at 0x11 gives 0xFFFFFFBE; unsigned gives 0x000000BE.
REQ-040 Half load at 0x12 signed from 0x5AADBEEF -> 0x00005AAD; half store at 0x11 -> rsp_err=1 and memory unchanged.
REQ-041 Load at addr 0x800 with ADDR_W=11, or with req_size=3 -> rsp_err=1, rsp_rdata=0.
REQ-042 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; req_ready=1 the cycle after rsp_ready=1.
REQ-043 Assert rst_n=0 during RD with RD_LAT=2 -> rsp_valid=0 immediately, no response after release; data stored before reset reads back intact.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory pipe: access sizes, FSM states and
// the per-request metadata kept while a response is outstanding.
// Latency: n/a (types and a pure function only). Backpressure: n/a.
// Contents: size_e, state_e, req_meta_t, load_extend().
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // Everything about an accepted request that the response path still needs.
  typedef struct packed {
    logic       we;
    size_e      size;
    logic       sgn;
    logic [1:0] lane;
    logic       err;
  } req_meta_t;

  // Pick the addressed byte/half out of a little-endian word, right-justify
  // it and sign- or zero-extend. Words pass through untouched.
  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input size_e       size,
    input logic [1:0]  lane,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    res = {{24{sgn & b[7]}}, b};
      SZ_H:    res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word RAM with per-byte write enables and one synchronous read port.
// Latency: read data appears the cycle after i_re; writes land on the posedge.
// Backpressure: none, every access is taken. Contents are never reset.
// Ports: clk; i_we[3:0] byte-lane enables; i_re read strobe; i_addr word
//        index; i_wdat lane-steered write data; o_rdat registered read data.
module dmem_bank #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdat,
  output logic [31:0]   o_rdat
);

  logic [31:0] r_mem [0:(1<<AW)-1];
  logic [31:0] r_rdat;

  // The read register only moves on i_re, so it holds its value for as long
  // as the owner leaves the port idle (the response hold relies on that).
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (i_we[k]) r_mem[i_addr][8*k +: 8] <= i_wdat[8*k +: 8];
    end
    if (i_re) r_rdat <= r_mem[i_addr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/dmem_pipe.sv
// Byte-addressable data memory with a valid/ready request and response port.
// Latency: store responds T+1, load responds T+RD_LAT (RD_LAT = 1 or 2).
// Backpressure: one request in flight; req_ready only in IDLE, response held
// until rsp_ready.
// Ports: clk, rst_n (async, active-low); req_valid/req_ready/req_we/req_size/
//        req_signed/req_addr/req_wdata in; rsp_valid/rsp_ready/rsp_rdata/
//        rsp_err out.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int WORD_AW = ADDR_W - 2;

  state_e      r_state;
  state_e      w_state_nxt;
  req_meta_t   r_meta;
  logic [31:0] r_ldat;

  logic        w_accept;
  size_e       w_size;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdat;
  logic [3:0]  w_bank_we;
  logic        w_bank_re;
  logic [31:0] w_bank_rdat;
  logic [31:0] w_ld_ext;
  logic [31:0] w_ld_src;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_size   = size_e'(req_size);

  // Anything at or above 2**ADDR_W is outside the array.
  always_comb begin
    w_err = 1'b0;
    case (w_size)
      SZ_H:    w_err = req_addr[0];
      SZ_W:    w_err = (req_addr[1:0] != 2'b00);
      SZ_BAD:  w_err = 1'b1;
      default: w_err = 1'b0;
    endcase
    if ((req_addr >> ADDR_W) != 32'd0) w_err = 1'b1;
  end

  // Lane steering: replicate the right-justified data across the word so
  // whichever lanes are enabled see the correct bytes.
  always_comb begin
    w_be   = 4'b0000;
    w_wdat = req_wdata;
    case (w_size)
      SZ_B: begin
        w_be   = 4'b0001 << req_addr[1:0];
        w_wdat = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        w_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{req_wdata[15:0]}};
      end
      SZ_W: begin
        w_be   = 4'b1111;
        w_wdat = req_wdata;
      end
      default: begin
        w_be   = 4'b0000;
        w_wdat = req_wdata;
      end
    endcase
  end

  // Errored requests never touch the array.
  assign w_bank_we = (w_accept && req_we && !w_err) ? w_be : 4'b0000;
  assign w_bank_re = w_accept && !req_we && !w_err;

  dmem_bank #(
    .AW (WORD_AW)
  ) u_bank (
    .clk    (clk),
    .i_we   (w_bank_we),
    .i_re   (w_bank_re),
    .i_addr (req_addr[ADDR_W-1:2]),
    .i_wdat (w_wdat),
    .o_rdat (w_bank_rdat)
  );

  assign w_ld_ext = load_extend(w_bank_rdat, r_meta.size, r_meta.lane, r_meta.sgn);
  // With RD_LAT=2 the extended load is registered in RD, taking the
  // extension logic out of the response path.
  assign w_ld_src = (RD_LAT == 2) ? r_ldat : w_ld_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_meta  <= '0;
      r_ldat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_meta.we   <= req_we;
        r_meta.size <= w_size;
        r_meta.sgn  <= req_signed;
        r_meta.lane <= req_addr[1:0];
        r_meta.err  <= w_err;
      end
      if (r_state == ST_RD) r_ldat <= w_ld_ext;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = 32'd0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = (!req_we && (RD_LAT == 2)) ? ST_RD : ST_RSP;
        end
      end
      ST_RD: begin
        w_state_nxt = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_meta.err;
        if (!r_meta.we && !r_meta.err) rsp_rdata = w_ld_src;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
